// File: rtl/hdmi_rx_sync.sv
// Pixel-stream receiver: recovers frame geometry from DE/HS/VS, emits x/y and frame markers,
// and passes video only after the measured timing has been stable for LOCK_FRAMES frames.
module hdmi_rx_sync #(
    parameter int   X_W         = 11,
    parameter int   Y_W         = 11,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_de,
    input  logic           in_hs,
    input  logic           in_vs,
    input  logic [7:0]     in_r,
    input  logic [7:0]     in_g,
    input  logic [7:0]     in_b,
    output logic           out_de,
    output logic [7:0]     out_r,
    output logic [7:0]     out_g,
    output logic [7:0]     out_b,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           out_sof,
    output logic           out_eol,
    output logic [X_W-1:0] width,
    output logic [Y_W-1:0] height,
    output logic           locked,
    output logic           err,
    output logic [3:0]     dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [X_W-1:0] X_MAX  = {X_W{1'b1}};
    localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};
    localparam logic [7:0]     LOCK_N = 8'(LOCK_FRAMES);

    state_t         state, state_nxt;
    logic           s1_de, s1_hs_a, s1_vs_a;
    logic [7:0]     s1_r, s1_g, s1_b;
    logic           de_d, vs_d;
    logic [X_W-1:0] x_cnt, first_len, prev_w;
    logic [Y_W-1:0] y_cnt, prev_h;
    logic [7:0]     good_cnt, good_nxt;
    logic           frame_bad;

    logic           de_v, de_rise, de_fall, vs_start, next_de, lk, checking;
    logic           x_sat, len_bad, de_in_vs, viol, mark_bad;
    logic           meas_ok, meas_match, lock_err, upd_geom;
    logic [X_W-1:0] cur_x;

    // DE seen during vertical sync is flagged but never enters the counters.
    assign de_v     = s1_de & ~s1_vs_a;
    assign de_rise  = de_v & ~de_d;
    assign de_fall  = ~de_v & de_d;
    assign vs_start = s1_vs_a & ~vs_d;
    assign next_de  = in_de & ~(in_vs == VS_POL);
    assign lk       = (state == LOCKED);
    assign checking = (state != SEARCH);
    assign cur_x    = de_rise ? '0 : x_cnt;

    assign x_sat    = de_v & ~de_rise & (x_cnt == X_MAX);
    assign len_bad  = de_fall & (y_cnt != '0) & (x_cnt != first_len);
    assign de_in_vs = s1_de & s1_vs_a;
    assign mark_bad = checking & (x_sat | len_bad);
    assign viol     = checking & (x_sat | len_bad | de_in_vs);

    assign meas_ok    = (first_len != '0) & (y_cnt != '0) & ~frame_bad;
    assign meas_match = meas_ok & (first_len == prev_w) & (y_cnt == prev_h);

    assign locked = lk;
    assign dbg    = {s1_hs_a, s1_vs_a, state};

    always_comb begin
        good_nxt = 8'd0;
        if (meas_match)
            good_nxt = (good_cnt >= LOCK_N) ? LOCK_N : good_cnt + 8'd1;
        else if (meas_ok)
            good_nxt = 8'd1;
    end

    always_comb begin
        state_nxt = state;
        lock_err  = 1'b0;
        upd_geom  = 1'b0;
        if (vs_start) begin
            case (state)
                SEARCH:  state_nxt = MEASURE;
                MEASURE: begin
                    if (good_nxt >= LOCK_N) begin
                        state_nxt = LOCKED;
                        upd_geom  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (meas_match) begin
                        upd_geom = 1'b1;
                    end else begin
                        state_nxt = MEASURE;
                        lock_err  = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            s1_de   <= 1'b0;
            s1_hs_a <= 1'b0;
            s1_vs_a <= 1'b0;
            s1_r    <= 8'd0;
            s1_g    <= 8'd0;
            s1_b    <= 8'd0;
            de_d    <= 1'b0;
            vs_d    <= 1'b0;
        end else begin
            state   <= state_nxt;
            s1_de   <= in_de;
            s1_hs_a <= (in_hs == HS_POL);
            s1_vs_a <= (in_vs == VS_POL);
            s1_r    <= in_r;
            s1_g    <= in_g;
            s1_b    <= in_b;
            de_d    <= de_v;
            vs_d    <= s1_vs_a;
        end
    end

    // x_cnt holds the number of DE pixels seen so far in the current line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            first_len <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (de_v)
                x_cnt <= de_rise ? X_W'(1) : ((x_cnt == X_MAX) ? X_MAX : x_cnt + X_W'(1));
            if (vs_start) begin
                y_cnt     <= '0;
                first_len <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (de_fall && y_cnt != Y_MAX)
                    y_cnt <= y_cnt + Y_W'(1);
                if (de_fall && y_cnt == '0)
                    first_len <= x_cnt;
                if (mark_bad)
                    frame_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= 8'd0;
            prev_w   <= '0;
            prev_h   <= '0;
            width    <= '0;
            height   <= '0;
            err      <= 1'b0;
        end else begin
            err <= viol | lock_err;
            if (vs_start) begin
                if (state == SEARCH) begin
                    good_cnt <= 8'd0;
                    prev_w   <= '0;
                    prev_h   <= '0;
                end else begin
                    good_cnt <= good_nxt;
                    prev_w   <= first_len;
                    prev_h   <= y_cnt;
                end
            end
            if (upd_geom) begin
                width  <= first_len;
                height <= y_cnt;
            end
        end
    end

    // End of line is known one pixel early by peeking at the unregistered DE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_de  <= 1'b0;
            out_sof <= 1'b0;
            out_eol <= 1'b0;
            out_x   <= '0;
            out_y   <= '0;
            out_r   <= 8'd0;
            out_g   <= 8'd0;
            out_b   <= 8'd0;
        end else begin
            out_de  <= de_v & lk;
            out_sof <= de_v & lk & (cur_x == '0) & (y_cnt == '0);
            out_eol <= de_v & lk & ~next_de;
            out_x   <= cur_x;
            out_y   <= y_cnt;
            out_r   <= s1_r;
            out_g   <= s1_g;
            out_b   <= s1_b;
        end
    end

endmodule

// File: tb/tb_hdmi_rx_sync.sv
// Bench for hdmi_rx_sync: a timing generator drives two instances (active-low and active-high
// syncs); pixels expected on the output are queued with their due cycle and checked on arrival.
module tb_hdmi_rx_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_de = 1'b0;
    logic        in_hs0 = 1'b1, in_vs0 = 1'b1, in_hs1 = 1'b0, in_vs1 = 1'b0;
    logic [7:0]  in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;

    logic        out_de0, out_sof0, out_eol0, locked0, err0;
    logic [7:0]  out_r0, out_g0, out_b0;
    logic [10:0] out_x0, out_y0, width0, height0;
    logic [3:0]  dbg0;
    logic        out_de1, out_sof1, out_eol1, locked1, err1;
    logic [7:0]  out_r1, out_g1, out_b1;
    logic [10:0] out_x1, out_y1, width1, height1;
    logic [3:0]  dbg1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    bit          push_en = 1'b0;
    logic [79:0] exp_q[$];

    typedef struct {
        int w; int h; int hb; int vb; int frames;
        bit exp_lock; int exp_w; int exp_h;
    } vec_t;
    vec_t vecs[3];

    hdmi_rx_sync u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs0), .in_vs(in_vs0),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_de(out_de0), .out_r(out_r0), .out_g(out_g0), .out_b(out_b0),
        .out_x(out_x0), .out_y(out_y0), .out_sof(out_sof0), .out_eol(out_eol0),
        .width(width0), .height(height0), .locked(locked0), .err(err0), .dbg(dbg0)
    );

    hdmi_rx_sync #(.HS_POL(1'b1), .VS_POL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs1), .in_vs(in_vs1),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_de(out_de1), .out_r(out_r1), .out_g(out_g1), .out_b(out_b1),
        .out_x(out_x1), .out_y(out_y1), .out_sof(out_sof1), .out_eol(out_eol1),
        .width(width1), .height(height1), .locked(locked1), .err(err1), .dbg(dbg1)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: one pixel per entry, tagged with the cycle it must appear on
    always @(negedge clk) begin
        logic [79:0] e;
        if (rst_n) begin
            if (err0) err_cnt++;
            if (out_de0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_de", 80'(cyc), 80'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {32'(cyc), out_x0, out_y0, out_sof0, out_eol0, out_r0, out_g0, out_b0}, e);
                end
            end else begin
                check("markers_idle", 80'({out_sof0, out_eol0}), 80'd0);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (e[79:48] == 32'(cyc)) begin
                        check("missing_pixel", 80'(out_de0), 80'd1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input logic de, input logic hs_act, input logic vs_act);
        @(posedge clk);
        #1;
        in_de  = de;
        in_hs0 = ~hs_act;
        in_vs0 = ~vs_act;
        in_hs1 = hs_act;
        in_vs1 = vs_act;
        in_r   = 8'($urandom_range(0, 255));
        in_g   = 8'($urandom_range(0, 255));
        in_b   = 8'($urandom_range(0, 255));
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_de = 1'b0; in_hs0 = 1'b1; in_vs0 = 1'b1; in_hs1 = 1'b0; in_vs1 = 1'b0;
        exp_q.delete();
        push_en = 1'b0;
        #1;
        check("reset_outputs", 80'({out_de0, out_sof0, out_eol0, locked0, err0, width0, height0,
                                    out_x0, out_y0, out_r0, locked1}), 80'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        err_cnt = 0;
    endtask

    task automatic blank_line(input int len, input bit vs_act, input bit glitch);
        for (int c = 0; c < len; c++)
            tick(glitch && c == 5, c >= 2 && c < 6, vs_act);
    endtask

    task automatic active_line(input int len, input int hb, input int y, input int rpix);
        for (int x = 0; x < len; x++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (push_en)
                exp_q.push_back({32'(cyc + 2), 11'(x), 11'(y), (x == 0 && y == 0), (x == len - 1),
                                 in_r, in_g, in_b});
            if (x == rpix) begin
                rst_n = 1'b0;
                exp_q.delete();
                push_en = 1'b0;
                #1;
                check("async_reset", 80'({out_de0, out_sof0, out_eol0, locked0, err0, width0,
                                          height0, out_x0, out_y0, out_r0, locked1}), 80'd0);
            end
            if (rpix >= 0 && x == rpix + 3) rst_n = 1'b1;
        end
        for (int c = 0; c < hb; c++)
            tick(1'b0, c >= 2 && c < 6, 1'b0);
    endtask

    task automatic run_frame(input int w, input int h, input int hb, input int vb, input bit exp_lock,
                             input int short_line, input bit glitch, input int rst_line);
        push_en = 1'b0;
        for (int l = 0; l < vb; l++)
            blank_line(w + hb, l < 3, glitch && l == 1);
        check("locked_after_vs", 80'({locked0, locked1}), 80'({exp_lock, exp_lock}));
        push_en = exp_lock;
        for (int y = 0; y < h; y++)
            active_line((y == short_line) ? w - 1 : w, hb, y, (y == rst_line) ? 10 : -1);
        push_en = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        check("queue_empty", 80'(exp_q.size()), 80'd0);
    endtask

    task automatic check_geom(input string name, input int w, input int h);
        check(name, 80'({width0, height0, width1, height1}), 80'({11'(w), 11'(h), 11'(w), 11'(h)}));
    endtask

    initial begin
        int base;
        vecs[0] = '{w: 32, h: 16, hb: 8,  vb: 4,  frames: 4, exp_lock: 1'b1, exp_w: 32, exp_h: 16};
        vecs[1] = '{w: 16, h: 8,  hb: 6,  vb: 3,  frames: 2, exp_lock: 1'b0, exp_w: 0,  exp_h: 0};
        vecs[2] = '{w: 64, h: 64, hb: 18, vb: 20, frames: 4, exp_lock: 1'b1, exp_w: 64, exp_h: 64};

        for (int i = 0; i < 3; i++) begin
            reset_dut();
            for (int f = 0; f < vecs[i].frames; f++)
                run_frame(vecs[i].w, vecs[i].h, vecs[i].hb, vecs[i].vb, f >= 2, -1, 1'b0, -1);
            drain();
            check("row_locked", 80'({locked0, locked1}), 80'({vecs[i].exp_lock, vecs[i].exp_lock}));
            check_geom("row_geometry", vecs[i].exp_w, vecs[i].exp_h);
            check("row_no_err", 80'(err_cnt), 80'd0);
        end

        // still locked on 64x64: one short line breaks lock, two good frames relock
        base = err_cnt;
        run_frame(64, 64, 18, 20, 1'b1, 10, 1'b0, -1);
        check("short_line_err", 80'(err_cnt - base), 80'd1);
        run_frame(64, 64, 18, 20, 1'b0, -1, 1'b0, -1);
        check("lock_loss_err", 80'(err_cnt - base), 80'd2);
        run_frame(64, 64, 18, 20, 1'b0, -1, 1'b0, -1);
        run_frame(64, 64, 18, 20, 1'b1, -1, 1'b0, -1);
        drain();
        check_geom("relock_geometry", 64, 64);

        // one DE cycle inside vsync while locked
        reset_dut();
        for (int f = 0; f < 4; f++)
            run_frame(32, 16, 8, 4, f >= 2, -1, 1'b0, -1);
        run_frame(32, 16, 8, 4, 1'b1, -1, 1'b1, -1);
        check("de_in_vsync_err", 80'(err_cnt), 80'd1);
        run_frame(32, 16, 8, 4, 1'b1, -1, 1'b0, -1);
        drain();
        check("de_in_vsync_err_once", 80'(err_cnt), 80'd1);
        check_geom("de_in_vsync_geometry", 32, 16);

        // reset mid-line while locked, then lock again after 1 + 2 frames
        reset_dut();
        for (int f = 0; f < 4; f++)
            run_frame(32, 16, 8, 4, f >= 2, -1, 1'b0, -1);
        run_frame(32, 16, 8, 4, 1'b1, -1, 1'b0, 5);
        check("post_reset_geometry_zero", 80'({width0, height0}), 80'd0);
        run_frame(32, 16, 8, 4, 1'b0, -1, 1'b0, -1);
        run_frame(32, 16, 8, 4, 1'b0, -1, 1'b0, -1);
        run_frame(32, 16, 8, 4, 1'b1, -1, 1'b0, -1);
        drain();
        check_geom("post_reset_geometry", 32, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
